// File: rtl/pixart_pkg.sv
// -----------------------------------------------------------------------------
// pixart_pkg
// Shared constants and FSM state encoding for the Pixart IR camera blob
// decoder. A blob record on the wire is three bytes and decodes to a 10-bit
// X, a 10-bit Y and a 4-bit size. An empty slot reads back as all-ones bytes.
// -----------------------------------------------------------------------------
package pixart_pkg;

  localparam int PIXART_COORD_W    = 10;
  localparam int PIXART_SIZE_W     = 4;
  localparam int PIXART_BLOB_BYTES = 3;

  localparam logic [PIXART_COORD_W-1:0] PIXART_INVALID_COORD = 10'h3FF;
  localparam logic [PIXART_SIZE_W-1:0]  PIXART_INVALID_SIZE  = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    BLOB,
    TAIL,
    DONE
  } pixart_state_e;

endpackage

// File: rtl/pixart_blob_unpack.sv
// -----------------------------------------------------------------------------
// pixart_blob_unpack
// Purely combinational decode of one 3-byte camera blob record.
//
// Ports:
//   b0, b1, b2 : the three record bytes in arrival order
//   x, y       : 10-bit coordinates, upper two bits taken from b2
//   size       : 4-bit blob size from b2[3:0]
//   valid      : 0 when all three bytes are 8'hFF (empty slot)
// -----------------------------------------------------------------------------
module pixart_blob_unpack
  import pixart_pkg::*;
(
  input  logic [7:0]                b0,
  input  logic [7:0]                b1,
  input  logic [7:0]                b2,
  output logic [PIXART_COORD_W-1:0] x,
  output logic [PIXART_COORD_W-1:0] y,
  output logic [PIXART_SIZE_W-1:0]  size,
  output logic                      valid
);

  // An empty slot is signalled by the camera as FF FF FF; it is forced to
  // the canonical "no blob" values so downstream code can rely on them.
  always_comb begin
    valid = ~((b0 == 8'hFF) && (b1 == 8'hFF) && (b2 == 8'hFF));
    if (valid) begin
      x    = {b2[5:4], b0};
      y    = {b2[7:6], b1};
      size = b2[3:0];
    end else begin
      x    = PIXART_INVALID_COORD;
      y    = PIXART_INVALID_COORD;
      size = PIXART_INVALID_SIZE;
    end
  end

endmodule

// File: rtl/pixart_blob_decoder.sv
// -----------------------------------------------------------------------------
// pixart_blob_decoder
// Assembles the byte stream of one Pixart camera read transaction (header,
// NUM_BLOBS 3-byte blob records, padding) into blob records held in shadow
// registers, then publishes the whole frame atomically with a one-cycle
// frame_valid strobe. A frame_start during a transaction aborts it with a
// one-cycle frame_error pulse and immediately begins the new frame.
//
// Ports:
//   clk          : system clock
//   reset        : asynchronous, active-low reset
//   frame_start  : pulse, a new read transaction begins
//   byte_in      : data byte from the I2C read engine
//   byte_valid   : byte_in valid this cycle (no backpressure)
//   blob_x       : X coordinates, blob n at [10n+9:10n]
//   blob_y       : Y coordinates, same packing
//   blob_size    : sizes, blob n at [4n+3:4n]
//   blob_valid   : 1 = blob n present
//   frame_valid  : pulse, outputs above have just updated
//   frame_error  : pulse, a transaction was aborted
//
// Build option:
//   PIXART_LOWPASS_EN : when defined, blob 0 X/Y are averaged with the
//                       previously published values whenever blob 0 is valid
//                       in both frames.
// -----------------------------------------------------------------------------
module pixart_blob_decoder
  import pixart_pkg::*;
#(
  parameter int FRAME_BYTES  = 16,
  parameter int HEADER_BYTES = 1,
  parameter int NUM_BLOBS    = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                frame_start,
  input  logic [7:0]                          byte_in,
  input  logic                                byte_valid,
  output logic [NUM_BLOBS*PIXART_COORD_W-1:0] blob_x,
  output logic [NUM_BLOBS*PIXART_COORD_W-1:0] blob_y,
  output logic [NUM_BLOBS*PIXART_SIZE_W-1:0]  blob_size,
  output logic [NUM_BLOBS-1:0]                blob_valid,
  output logic                                frame_valid,
  output logic                                frame_error
);

  localparam int CNT_W = $clog2(FRAME_BYTES + 1);
  localparam int IDX_W = (NUM_BLOBS > 1) ? $clog2(NUM_BLOBS) : 1;

  localparam logic [CNT_W-1:0] HDR_LAST   = CNT_W'(HEADER_BYTES - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BYTES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_BLOBS - 1);
  localparam logic [1:0]       SUB_LAST   = 2'(PIXART_BLOB_BYTES - 1);

  pixart_state_e state, state_next, eff_state;

  logic [CNT_W-1:0] byte_cnt, cnt_next, eff_cnt;
  logic [1:0]       sub_cnt, sub_next, eff_sub;
  logic [IDX_W-1:0] blob_idx, idx_next, eff_idx;

  logic [7:0] hold0, hold1;
  logic       hold0_en, hold1_en, store_en;
  logic       take, publish, error_next;

  logic [NUM_BLOBS*PIXART_COORD_W-1:0] shadow_x, shadow_y;
  logic [NUM_BLOBS*PIXART_SIZE_W-1:0]  shadow_size;
  logic [NUM_BLOBS-1:0]                shadow_valid;

  logic [NUM_BLOBS*PIXART_COORD_W-1:0] pub_x, pub_y;

  logic [PIXART_COORD_W-1:0] unp_x, unp_y;
  logic [PIXART_SIZE_W-1:0]  unp_size;
  logic                      unp_valid;

  // The first two bytes of a record wait in hold0/hold1; the record is
  // decoded in the cycle its third byte arrives.
  pixart_blob_unpack u_unpack (
    .b0   (hold0),
    .b1   (hold1),
    .b2   (byte_in),
    .x    (unp_x),
    .y    (unp_y),
    .size (unp_size),
    .valid(unp_valid)
  );

  // The "effective" state is where this cycle's byte is interpreted: a
  // frame_start from any state restarts at HEADER with counters cleared, so
  // a byte arriving alongside it is byte 0 of the new frame. DONE without
  // frame_start behaves as IDLE for incoming bytes.
  always_comb begin
    eff_state = state;
    eff_cnt   = byte_cnt;
    eff_sub   = sub_cnt;
    eff_idx   = blob_idx;
    if (frame_start) begin
      eff_state = HEADER;
      eff_cnt   = '0;
      eff_sub   = '0;
      eff_idx   = '0;
    end else if (state == DONE) begin
      eff_state = IDLE;
    end

    state_next = eff_state;
    cnt_next   = eff_cnt;
    sub_next   = eff_sub;
    idx_next   = eff_idx;
    hold0_en   = 1'b0;
    hold1_en   = 1'b0;
    store_en   = 1'b0;
    publish    = (state == DONE);
    error_next = frame_start &&
                 ((state == HEADER) || (state == BLOB) || (state == TAIL));
    take       = byte_valid &&
                 ((eff_state == HEADER) || (eff_state == BLOB) || (eff_state == TAIL));

    if (take) begin
      cnt_next = eff_cnt + 1'b1;
      case (eff_state)
        HEADER: begin
          if (eff_cnt == HDR_LAST) begin
            state_next = BLOB;
          end
        end
        BLOB: begin
          if (eff_sub == SUB_LAST) begin
            store_en = 1'b1;
            sub_next = '0;
            if (eff_idx == IDX_LAST) begin
              idx_next   = '0;
              state_next = (eff_cnt == FRAME_LAST) ? DONE : TAIL;
            end else begin
              idx_next = eff_idx + 1'b1;
            end
          end else begin
            hold0_en = (eff_sub == 2'd0);
            hold1_en = (eff_sub == 2'd1);
            sub_next = eff_sub + 1'b1;
          end
        end
        TAIL: begin
          if (eff_cnt == FRAME_LAST) begin
            state_next = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Control state and byte bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      byte_cnt <= '0;
      sub_cnt  <= '0;
      blob_idx <= '0;
    end else begin
      state    <= state_next;
      byte_cnt <= cnt_next;
      sub_cnt  <= sub_next;
      blob_idx <= idx_next;
    end
  end

  // Record assembly into the shadow copy. An aborted frame may leave some
  // shadow entries overwritten, but every completed frame rewrites all of
  // them before DONE, so the published frame is never mixed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold0        <= '0;
      hold1        <= '0;
      shadow_x     <= {NUM_BLOBS{PIXART_INVALID_COORD}};
      shadow_y     <= {NUM_BLOBS{PIXART_INVALID_COORD}};
      shadow_size  <= '0;
      shadow_valid <= '0;
    end else begin
      if (hold0_en) begin
        hold0 <= byte_in;
      end
      if (hold1_en) begin
        hold1 <= byte_in;
      end
      if (store_en) begin
        shadow_x[int'(eff_idx)*PIXART_COORD_W +: PIXART_COORD_W]   <= unp_x;
        shadow_y[int'(eff_idx)*PIXART_COORD_W +: PIXART_COORD_W]   <= unp_y;
        shadow_size[int'(eff_idx)*PIXART_SIZE_W +: PIXART_SIZE_W]  <= unp_size;
        shadow_valid[eff_idx]                                      <= unp_valid;
      end
    end
  end

`ifdef PIXART_LOWPASS_EN
  logic [PIXART_COORD_W:0] sum_x0, sum_y0;

  // Blob 0 is smoothed only when both the outgoing and incoming samples are
  // real detections; averaging against the 3FF "no blob" marker would be
  // meaningless.
  always_comb begin
    pub_x  = shadow_x;
    pub_y  = shadow_y;
    sum_x0 = {1'b0, blob_x[PIXART_COORD_W-1:0]} + {1'b0, shadow_x[PIXART_COORD_W-1:0]};
    sum_y0 = {1'b0, blob_y[PIXART_COORD_W-1:0]} + {1'b0, shadow_y[PIXART_COORD_W-1:0]};
    if (blob_valid[0] && shadow_valid[0]) begin
      pub_x[PIXART_COORD_W-1:0] = PIXART_COORD_W'(sum_x0 >> 1);
      pub_y[PIXART_COORD_W-1:0] = PIXART_COORD_W'(sum_y0 >> 1);
    end
  end
`else
  assign pub_x = shadow_x;
  assign pub_y = shadow_y;
`endif

  // Published outputs and strobes. Everything consumers see changes on the
  // single edge that leaves DONE, together with the frame_valid pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blob_x      <= {NUM_BLOBS{PIXART_INVALID_COORD}};
      blob_y      <= {NUM_BLOBS{PIXART_INVALID_COORD}};
      blob_size   <= '0;
      blob_valid  <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_valid <= publish;
      frame_error <= error_next;
      if (publish) begin
        blob_x     <= pub_x;
        blob_y     <= pub_y;
        blob_size  <= shadow_size;
        blob_valid <= shadow_valid;
      end
    end
  end

endmodule

// File: tb/tb_pixart_blob_decoder.sv
// -----------------------------------------------------------------------------
// tb_pixart_blob_decoder
// Directed and randomized frames for pixart_blob_decoder, compared against a
// frame-level reference model that decodes whole byte arrays arithmetically.
// Honours PIXART_LOWPASS_EN in the model when the design is built with it.
// -----------------------------------------------------------------------------
module tb_pixart_blob_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic [39:0] blob_x;
  logic [39:0] blob_y;
  logic [15:0] blob_size;
  logic [3:0]  blob_valid;
  logic        frame_valid;
  logic        frame_error;

  int checks = 0;
  int errors = 0;
  int fvCount = 0;
  int feCount = 0;

  logic [7:0] txFrame [16];
  int         expX [4];
  int         expY [4];
  int         expS [4];
  bit         expV [4];

  pixart_blob_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .blob_x     (blob_x),
    .blob_y     (blob_y),
    .blob_size  (blob_size),
    .blob_valid (blob_valid),
    .frame_valid(frame_valid),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  // Pulse counters, used to prove strobes fire exactly when expected.
  always @(posedge clk) begin
    if (frame_valid === 1'b1) fvCount <= fvCount + 1;
    if (frame_error === 1'b1) feCount <= feCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [39:0] obs, input logic [39:0] expected);
    checks++;
    assert (obs === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    logic [39:0] ex, ey;
    logic [15:0] es;
    logic [3:0]  ev;
    for (int n = 0; n < 4; n++) begin
      ex[n*10 +: 10] = expX[n][9:0];
      ey[n*10 +: 10] = expY[n][9:0];
      es[n*4 +: 4]   = expS[n][3:0];
      ev[n]          = expV[n];
    end
    checkOutput({tag, "_x"}, blob_x, ex);
    checkOutput({tag, "_y"}, blob_y, ey);
    checkOutput({tag, "_size"}, {24'd0, blob_size}, {24'd0, es});
    checkOutput({tag, "_valid"}, {36'd0, blob_valid}, {36'd0, ev});
  endtask

  // One clock of stimulus; returns 1 time unit after the edge.
  task automatic applyStimulus(input bit fs, input bit bv, input logic [7:0] b);
    frame_start = fs;
    byte_valid  = bv;
    byte_in     = b;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    byte_valid  = 1'b0;
  endtask

  task automatic modelReset();
    for (int n = 0; n < 4; n++) begin
      expX[n] = 1023;
      expY[n] = 1023;
      expS[n] = 0;
      expV[n] = 1'b0;
    end
  endtask

  // Decode the whole of txFrame from the byte layout: 1 header byte, then
  // four 3-byte records.
  task automatic modelPublish();
    int nx, ny, ns;
    bit nv;
    logic [7:0] b0, b1, b2;
    for (int n = 0; n < 4; n++) begin
      b0 = txFrame[1 + 3*n];
      b1 = txFrame[2 + 3*n];
      b2 = txFrame[3 + 3*n];
      nv = !(b0 == 8'hFF && b1 == 8'hFF && b2 == 8'hFF);
      if (nv) begin
        nx = int'(b2[5:4]) * 256 + int'(b0);
        ny = int'(b2[7:6]) * 256 + int'(b1);
        ns = int'(b2[3:0]);
      end else begin
        nx = 1023;
        ny = 1023;
        ns = 15;
      end
`ifdef PIXART_LOWPASS_EN
      if (n == 0 && expV[0] && nv) begin
        nx = (expX[0] + nx) / 2;
        ny = (expY[0] + ny) / 2;
      end
`endif
      expX[n] = nx;
      expY[n] = ny;
      expS[n] = ns;
      expV[n] = nv;
    end
  endtask

  task automatic setBlob(input int n, input int x, input int y, input int s);
    logic [9:0] xv, yv;
    logic [3:0] sv;
    xv = x[9:0];
    yv = y[9:0];
    sv = s[3:0];
    txFrame[1 + 3*n] = xv[7:0];
    txFrame[2 + 3*n] = yv[7:0];
    txFrame[3 + 3*n] = {yv[9:8], xv[9:8], sv};
  endtask

  task automatic setInvalid(input int n);
    txFrame[1 + 3*n] = 8'hFF;
    txFrame[2 + 3*n] = 8'hFF;
    txFrame[3 + 3*n] = 8'hFF;
  endtask

  task automatic buildRandom(input logic [3:0] mask);
    int x, y, s;
    for (int i = 0; i < 16; i++) txFrame[i] = 8'($urandom);
    for (int n = 0; n < 4; n++) begin
      if (mask[n]) begin
        x = int'($urandom_range(1023, 0));
        y = int'($urandom_range(1023, 0));
        s = int'($urandom_range(15, 0));
        if (x == 1023 && y == 1023 && s == 15) s = 14;
        setBlob(n, x, y, s);
      end else begin
        setInvalid(n);
      end
    end
  endtask

  // Sends txFrame after a frame_start. The first step may carry byte 0,
  // may abort a running frame, or may be the DONE cycle of the previous one.
  task automatic sendFrame(input bit withByte, input int maxGap,
                           input bit expectAbort, input bit pendingPublish);
    int i0;
    if (withByte) begin
      applyStimulus(1'b1, 1'b1, txFrame[0]);
      i0 = 1;
    end else begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      i0 = 0;
    end
    checkOutput("frame_error_at_start", {39'd0, frame_error}, {39'd0, expectAbort});
    checkOutput("frame_valid_at_start", {39'd0, frame_valid}, {39'd0, pendingPublish});
    checkAll("outputs_at_start");
    for (int i = i0; i < 16; i++) begin
      repeat ($urandom_range(maxGap, 0)) applyStimulus(1'b0, 1'b0, 8'($urandom));
      applyStimulus(1'b0, 1'b1, txFrame[i]);
    end
    checkOutput("frame_valid_on_last_byte", {39'd0, frame_valid}, 40'd0);
    checkAll("outputs_before_publish");
  endtask

  task automatic sendPartial(input int count);
    applyStimulus(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < count; i++) applyStimulus(1'b0, 1'b1, txFrame[i]);
  endtask

  task automatic finishFrame();
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("frame_valid_pulse", {39'd0, frame_valid}, 40'd1);
    checkAll("outputs_published");
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("frame_valid_single", {39'd0, frame_valid}, 40'd0);
    checkOutput("frame_error_idle", {39'd0, frame_error}, 40'd0);
  endtask

  initial begin
    int fv0, fe0, lpX, lpY;

    reset       = 1'b0;
    frame_start = 1'b0;
    byte_valid  = 1'b0;
    byte_in     = 8'h00;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkAll("reset");
    checkOutput("reset_frame_valid", {39'd0, frame_valid}, 40'd0);
    checkOutput("reset_frame_error", {39'd0, frame_error}, 40'd0);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);

    $display("[TB] basic frame");
    for (int i = 0; i < 16; i++) txFrame[i] = 8'h00;
    txFrame[1] = 8'h34;
    txFrame[2] = 8'h12;
    txFrame[3] = 8'hB5;
    for (int n = 1; n < 4; n++) setInvalid(n);
    fv0 = fvCount;
    sendFrame(1'b0, 0, 1'b0, 1'b0);
    modelPublish();
    finishFrame();
    checkOutput("t2_x0", {30'd0, blob_x[9:0]}, 40'h334);
    checkOutput("t2_y0", {30'd0, blob_y[9:0]}, 40'h212);
    checkOutput("t2_size0", {36'd0, blob_size[3:0]}, 40'd5);
    checkOutput("t2_valid", {36'd0, blob_valid}, 40'b0001);
    checkOutput("t2_invalid_x3", {30'd0, blob_x[39:30]}, 40'h3FF);
    checkOutput("t2_fv_count", fvCount - fv0, 40'd1);

    $display("[TB] four valid blobs, frame_start with byte 0");
    buildRandom(4'b0000);
    setBlob(0, 0, 1023, 3);
    setBlob(1, 1023, 0, 15);
    setBlob(2, 512, 300, 0);
    setBlob(3, 77, 901, 9);
    sendFrame(1'b1, 0, 1'b0, 1'b0);
    modelPublish();
    finishFrame();
    checkOutput("t3_valid", {36'd0, blob_valid}, 40'b1111);
    checkOutput("t3_x123", {10'd0, blob_x[39:10]}, {10'd0, 10'd77, 10'd512, 10'd1023});
    checkOutput("t3_size", {24'd0, blob_size}, 40'h9_0_F_3);

    $display("[TB] aborted frames");
    fe0 = feCount;
    buildRandom(4'($urandom));
    sendPartial(7);
    buildRandom(4'($urandom));
    sendFrame(1'b0, 0, 1'b1, 1'b0);
    modelPublish();
    finishFrame();
    checkOutput("t4_fe_count", feCount - fe0, 40'd1);
    buildRandom(4'($urandom));
    sendPartial(11);
    buildRandom(4'($urandom));
    sendFrame(1'b1, 2, 1'b1, 1'b0);
    modelPublish();
    finishFrame();
    checkOutput("t4_fe_count2", feCount - fe0, 40'd2);

    $display("[TB] stray bytes in IDLE, then gapped frame");
    fv0 = fvCount;
    fe0 = feCount;
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(5, 0)) applyStimulus(1'b0, 1'b0, 8'h00);
      applyStimulus(1'b0, 1'b1, 8'($urandom));
    end
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    checkAll("idle_bytes");
    checkOutput("idle_fv_count", fvCount - fv0, 40'd0);
    checkOutput("idle_fe_count", feCount - fe0, 40'd0);
    buildRandom(4'b1011);
    sendFrame(1'b0, 5, 1'b0, 1'b0);
    modelPublish();
    finishFrame();

    $display("[TB] back-to-back frames, frame_start in DONE");
    buildRandom(4'($urandom));
    sendFrame(1'b0, 1, 1'b0, 1'b0);
    modelPublish();
    buildRandom(4'($urandom));
    sendFrame(1'b1, 1, 1'b0, 1'b1);
    modelPublish();
    finishFrame();

    $display("[TB] randomized frames");
    for (int k = 0; k < 20; k++) begin
      buildRandom(4'($urandom));
      sendFrame(1'($urandom), 3, 1'b0, 1'b0);
      modelPublish();
      finishFrame();
    end

    $display("[TB] reset mid-frame");
    fv0 = fvCount;
    fe0 = feCount;
    buildRandom(4'b1111);
    sendPartial(9);
    #2;
    reset = 1'b0;
    #1;
    modelReset();
    checkAll("async_reset");
    checkOutput("async_reset_fv", {39'd0, frame_valid}, 40'd0);
    checkOutput("async_reset_fe", {39'd0, frame_error}, 40'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 9; i < 16; i++) applyStimulus(1'b0, 1'b1, txFrame[i]);
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    checkAll("after_reset");
    checkOutput("reset_fv_count", fvCount - fv0, 40'd0);
    checkOutput("reset_fe_count", feCount - fe0, 40'd0);

    $display("[TB] blob 0 smoothing sequence");
    buildRandom(4'b1110);
    sendFrame(1'b0, 0, 1'b0, 1'b0);
    modelPublish();
    finishFrame();
    buildRandom(4'b1110);
    setBlob(0, 100, 40, 2);
    sendFrame(1'b0, 0, 1'b0, 1'b0);
    modelPublish();
    finishFrame();
    checkOutput("lp_frame_a_x", {30'd0, blob_x[9:0]}, 40'd100);
    buildRandom(4'b1110);
    setBlob(0, 201, 61, 7);
    sendFrame(1'b0, 0, 1'b0, 1'b0);
    modelPublish();
    finishFrame();
`ifdef PIXART_LOWPASS_EN
    lpX = 150;
    lpY = 50;
`else
    lpX = 201;
    lpY = 61;
`endif
    checkOutput("lp_frame_b_x", {30'd0, blob_x[9:0]}, 40'(lpX));
    checkOutput("lp_frame_b_y", {30'd0, blob_y[9:0]}, 40'(lpY));
    buildRandom(4'b1110);
    sendFrame(1'b0, 0, 1'b0, 1'b0);
    modelPublish();
    finishFrame();
    checkOutput("lp_frame_c_x", {30'd0, blob_x[9:0]}, 40'h3FF);
    checkOutput("lp_frame_c_valid0", {39'd0, blob_valid[0]}, 40'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
